// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS definitions: sync headers, clause 49 lock
// defaults, lock-state encoding and a sync-header validity helper.
package pcs_pkg;

  localparam int HEAD_W = 2;

  localparam logic [HEAD_W-1:0] SYNC_HEAD_CTRL = 2'b10;
  localparam logic [HEAD_W-1:0] SYNC_HEAD_DATA = 2'b01;

  localparam int SH_CNT_N       = 64;
  localparam int SH_INV_MAX     = 16;
  localparam int SLIP_WAIT_N    = 2;
  localparam int HI_BER_TIMER_N = 20141;
  localparam int HI_BER_MAX     = 16;

  typedef enum logic [1:0] {
    LS_TEST = 2'd0,
    LS_SLIP = 2'd1,
    LS_WAIT = 2'd2
  } lock_state_e;

  function automatic logic sh_valid(
    input logic [HEAD_W-1:0] h
  );
    return h[1] ^ h[0];
  endfunction

endpackage

// File: rtl/pcs_rx_block_lock_if.sv
// Gearbox <-> block-lock bundle.
// master = gearbox side, slave = lock engine.
interface pcs_rx_block_lock_if;
  import pcs_pkg::*;

  logic              valid_i;
  logic [HEAD_W-1:0] head_i;
  logic              slip_v_o;
  logic              lock_v_o;
  logic              hi_ber_v_o;

  modport master (
    output valid_i, head_i,
    input  slip_v_o, lock_v_o, hi_ber_v_o
  );

  modport slave (
    input  valid_i, head_i,
    output slip_v_o, lock_v_o, hi_ber_v_o
  );

endinterface

// File: rtl/pcs_rx_block_lock_hi_ber.sv
// High-BER monitor: counts bad sync headers while locked over a
// free-running window; only built with PCS_RX_HI_BER_EN.
// Ports: clk, reset (async, high), valid_i, sh_ok, lock_i -> hi_ber_o.
`ifdef PCS_RX_HI_BER_EN
module pcs_rx_hi_ber #(
  parameter int TIMER_N = 20141,
  parameter int BER_MAX = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_i,
  input  logic sh_ok,
  input  logic lock_i,
  output logic hi_ber_o
);

  localparam int TW = $clog2(TIMER_N);

  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    ber_q, ber_d;
  logic          hi_q, hi_d;
  logic          wrap;

  always_comb begin
    wrap    = (timer_q == TW'(TIMER_N - 1));
    timer_d = wrap ? '0 : timer_q + TW'(1);
    hi_d    = hi_q | (ber_q >= 5'(BER_MAX));
    ber_d   = ber_q;
    if (!lock_i)
      ber_d = '0;
    else if (valid_i && !sh_ok && ber_q != 5'h1f)
      ber_d = ber_q + 5'd1;
    // A window that stayed below the limit clears the flag.
    if (wrap) begin
      ber_d = '0;
      if (ber_q < 5'(BER_MAX))
        hi_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      ber_q   <= '0;
      hi_q    <= 1'b0;
    end else begin
      timer_q <= timer_d;
      ber_q   <= ber_d;
      hi_q    <= hi_d;
    end
  end

  assign hi_ber_o = hi_q;

endmodule
`endif

// File: rtl/pcs_rx_block_lock.sv
// 10GBASE-R RX block lock: slips the gearbox until SH_CNT_N clean
// sync headers are seen, then holds lock until SH_INV_MAX bad ones
// land in one window. Optional hi-BER monitor: PCS_RX_HI_BER_EN.
// Ports: clk, reset (async, high), bl (slave: valid_i, head_i in;
// slip_v_o, lock_v_o, hi_ber_v_o out).
module pcs_rx_block_lock #(
  parameter int SH_CNT_N       = pcs_pkg::SH_CNT_N,
  parameter int SH_INV_MAX     = pcs_pkg::SH_INV_MAX,
`ifdef PCS_RX_HI_BER_EN
  parameter int HI_BER_TIMER_N = pcs_pkg::HI_BER_TIMER_N,
  parameter int HI_BER_MAX     = pcs_pkg::HI_BER_MAX,
`endif
  parameter int SLIP_WAIT_N    = pcs_pkg::SLIP_WAIT_N
) (
  input  logic                      clk,
  input  logic                      reset,
  pcs_rx_block_lock_if.slave        bl
);
  import pcs_pkg::*;

  localparam logic [1:0] TEST = LS_TEST;
  localparam logic [1:0] SLIP = LS_SLIP;
  localparam logic [1:0] WAIT = LS_WAIT;
  localparam int WW = $clog2(SLIP_WAIT_N + 1);

  logic [1:0]    state_q, state_d;
  logic [6:0]    sh_cnt_q, sh_cnt_d, sh_cnt_inc;
  logic [4:0]    inv_q, inv_d, inv_inc;
  logic [WW-1:0] wait_q, wait_d;
  logic          lock_q, lock_d;
  logic          sh_ok;

  assign sh_ok = sh_valid(bl.head_i);

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    inv_d      = inv_q;
    wait_d     = wait_q;
    lock_d     = lock_q;
    sh_cnt_inc = sh_cnt_q + 7'd1;
    inv_inc    = inv_q + {4'd0, ~sh_ok};
    unique case (1'b1)
      (state_q == TEST): begin
        if (bl.valid_i) begin
          sh_cnt_d = sh_cnt_inc;
          inv_d    = inv_inc;
          // Slip takes priority over window end.
          if (!sh_ok &&
              (!lock_q || inv_inc == 5'(SH_INV_MAX))) begin
            state_d = SLIP;
          end else if (sh_cnt_inc == 7'(SH_CNT_N)) begin
            if (inv_inc == 5'd0)
              lock_d = 1'b1;
            sh_cnt_d = '0;
            inv_d    = '0;
          end
        end
      end
      (state_q == SLIP): begin
        state_d  = WAIT;
        lock_d   = 1'b0;
        sh_cnt_d = '0;
        inv_d    = '0;
        wait_d   = '0;
      end
      (state_q == WAIT): begin
        if (bl.valid_i) begin
          if (wait_q == WW'(SLIP_WAIT_N - 1)) begin
            state_d = TEST;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
      end
      default: state_d = TEST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= TEST;
      sh_cnt_q <= '0;
      inv_q    <= '0;
      wait_q   <= '0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_cnt_q <= sh_cnt_d;
      inv_q    <= inv_d;
      wait_q   <= wait_d;
      lock_q   <= lock_d;
    end
  end

  assign bl.slip_v_o = (state_q == SLIP);
  assign bl.lock_v_o = lock_q;

`ifdef PCS_RX_HI_BER_EN
  pcs_rx_hi_ber #(
    .TIMER_N (HI_BER_TIMER_N),
    .BER_MAX (HI_BER_MAX)
  ) u_hi_ber (
    .clk      (clk),
    .reset    (reset),
    .valid_i  (bl.valid_i),
    .sh_ok    (sh_ok),
    .lock_i   (lock_q),
    .hi_ber_o (bl.hi_ber_v_o)
  );
`else
  assign bl.hi_ber_v_o = 1'b0;
`endif

endmodule

// File: doc/pcs_rx_block_lock.md
Name: pcs_rx_block_lock

Overview:
- 10GBASE-R receive block-lock engine (IEEE 802.3 cl.49.2.13 lock_state), receive-side counterpart of TX sync-header insertion.
- Inspects the 2-bit sync header of each 66b block from the RX gearbox and drives a one-cycle slip request back to the gearbox until alignment is found.
- Asserts block lock for the descrambler/decoder.

Parameters:
- SH_CNT_N, 64, valid-header window length for lock/unlock evaluation.
- SH_INV_MAX, 16, invalid headers within a window that force loss of lock.
- SLIP_WAIT_N, 2, valid blocks ignored after a slip while the gearbox realigns.
- HI_BER_TIMER_N, 20141, clk cycles in the 125 us BER window at 161.13 MHz.
- HI_BER_MAX, 16, invalid headers per window that flag hi_ber.

Ports:
- clk  in  1  logic clock, 161.13 MHz.
- reset  in  1  asynchronous, active-high reset.
- valid_i  in  1  head_i qualifies a new 66b block this cycle.
- head_i  in  2  sync header; valid = 2'b01 or 2'b10.
- slip_v_o  out  1  one-cycle pulse: gearbox shifts alignment by one bit.
- lock_v_o  out  1  block_lock.
- hi_ber_v_o  out  1  high bit-error-rate flag; constant 0 when feature is compiled out.

Behaviour:
- Reset (async, active-high), all outputs and state cleared:
  - slip_v_o=0, lock_v_o=0, hi_ber_v_o=0
  - sh_cnt=0, sh_inv_cnt=0, wait_cnt=0
  - state=TEST
- Datapath:
  - sh_valid = head_i[1]^head_i[0].
  - Only cycles with valid_i=1 are evaluated; valid_i=0 holds all state.
- Counters:
  - sh_cnt is 7 bits; sh_inv_cnt is 5 bits.
  - Neither counter wraps. Window end resets both to 0.
- States:
  - TEST: evaluate each valid header.
    - sh_cnt+1 always; sh_inv_cnt+1 if header invalid.
    - Invalid header with lock_v_o=0: go to SLIP immediately.
    - Invalid header with lock_v_o=1 that makes sh_inv_cnt reach SH_INV_MAX: go to SLIP.
    - When sh_cnt reaches SH_CNT_N and sh_inv_cnt==0: lock_v_o<=1, counters cleared.
    - When sh_cnt reaches SH_CNT_N and 0<sh_inv_cnt<SH_INV_MAX (locked): lock_v_o held, counters cleared.
  - SLIP: one cycle only.
    - slip_v_o=1, lock_v_o<=0, counters cleared, wait_cnt=0.
    - Go to WAIT.
  - WAIT: count valid blocks, ignoring headers.
    - After SLIP_WAIT_N valid blocks, go to TEST.
- Latency: slip_v_o asserts on the cycle after the offending valid_i; lock_v_o rises on the cycle after the 64th consecutive valid header.
- Boundaries:
  - Invalid header on the 64th block while unlocked: SLIP wins over window end.
  - While locked, the 16th invalid header coinciding with the 64th block: SLIP wins.
  - valid_i during SLIP is dropped (not counted).
  - Reset mid-WAIT returns to TEST with counters 0.
  - slip_v_o is never high on two consecutive cycles.
  - Minimum spacing between slips is SLIP_WAIT_N+2 cycles.

Optional Feature:
- Macro: PCS_RX_HI_BER_EN.
- Defined: free-running timer counts 0..HI_BER_TIMER_N-1 on every clk.
  - ber_cnt (5 bits, saturates) increments on each valid_i with an invalid header while lock_v_o=1.
  - ber_cnt reaching HI_BER_MAX sets hi_ber_v_o on the next cycle.
  - At timer wrap: hi_ber_v_o<=0 if the window's count was below HI_BER_MAX; ber_cnt and timer restart.
  - lock_v_o=0 clears ber_cnt (timer keeps running).
- Undefined: timer and counter absent; hi_ber_v_o tied 0.

Decomposition:
- Shared PCS package (pcs_pkg) holds:
  - SYNC_HEAD_CTRL=2'b10, SYNC_HEAD_DATA=2'b01, HEAD_W=2
  - lock-state enum {TEST, SLIP, WAIT}
  - cl.49 defaults SH_CNT_N, SH_INV_MAX, HI_BER_TIMER_N
- Natural sub-module: pcs_rx_hi_ber, holding the BER timer, counter and flag; instantiated only under PCS_RX_HI_BER_EN.

Test Plan:
- Reset then 64 valid blocks with head 2'b01 -> no slip_v_o; lock_v_o=1 exactly one cycle after 64th valid_i.
- Unlocked, head 2'b00 on block 5 -> slip_v_o single pulse next cycle.
  - Next 2 valid blocks are ignored (no slip even with 2'b11).
  - Counters restart; lock after 64 more good headers.
- Locked, 15 invalid headers scattered in a 64 window -> lock held.
  - Next window, 16th invalid -> slip_v_o pulse, lock_v_o=0.
- Locked, 16th invalid lands on 64th block -> slip, not window clear.
  - valid_i gaps (valid_i=0 for 3 cycles mid-window) don't advance sh_cnt.
- Reset asserted asynchronously mid-WAIT and mid-lock -> all outputs 0 immediately; clean relock after release.
- With PCS_RX_HI_BER_EN, HI_BER_TIMER_N=200:
  - 16 invalid headers in the window -> hi_ber_v_o=1.
  - Following clean window -> hi_ber_v_o=0 at timer wrap.
  - Without the macro, hi_ber_v_o stays 0.
